// File: rtl/rvm_shifter.sv
// rvm_shifter: multi-cycle 32-bit SLL/SRL/SRA unit with req/ready issue and valid/ack result handshakes.
// Define RVM_SHIFTER_FAST_EN to step by 4 bit positions per cycle while at least 4 remain.
module rvm_shifter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] lhs,
  input  logic [4:0]  shamt,
  output logic        ready,
  output logic        valid,
  output logic [31:0] result,
  input  logic        ack
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;
  logic [1:0]  state_q, state_d, op_q, op_d;
  logic [31:0] acc_q, acc_d, shifted;
  logic [4:0]  cnt_q, cnt_d, step;
`ifdef RVM_SHIFTER_FAST_EN
  assign step = (cnt_q >= 5'd4) ? 5'd4 : 5'd1;
`else
  assign step = 5'd1;
`endif
  assign shifted = (op_q == OP_SLL) ? acc_q << step :
                   (op_q == OP_SRA) ? $unsigned($signed(acc_q) >>> step) :
                                      acc_q >> step;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (state_q == IDLE && req && op != 2'b00) begin
      acc_d   = lhs;
      cnt_d   = shamt;
      op_d    = op;
      state_d = (shamt == 5'd0) ? DONE : SHIFT;
    end else if (state_q == SHIFT) begin
      acc_d   = shifted;
      cnt_d   = cnt_q - step;
      state_d = (cnt_q == step) ? DONE : SHIFT;
    end else if (state_q == DONE && ack) begin
      state_d = IDLE;
    end else if (state_q == 2'd3) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
  assign ready  = (state_q == IDLE);
  assign valid  = (state_q == DONE);
  // Zero-gated so the result can be OR-combined onto a shared bus
  assign result = valid ? acc_q : 32'd0;
endmodule

// File: tb/tb_rvm_shifter.sv
// tb_rvm_shifter: scoreboard bench for rvm_shifter covering latency, results, handshakes and reset.
module tb_rvm_shifter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] lhs = '0;
  logic [4:0]  shamt = '0;
  logic        ready, valid, ack = 1'b0;
  logic [31:0] result;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  rvm_shifter dut (
    .clk(clk), .resetn(resetn), .req(req), .op(op), .lhs(lhs), .shamt(shamt),
    .ready(ready), .valid(valid), .result(result), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] l, input logic [4:0] s);
    case (o)
      2'b01:   return l << s;
      2'b10:   return l >> s;
      2'b11:   return $unsigned($signed(l) >>> s);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] s);
`ifdef RVM_SHIFTER_FAST_EN
    return int'(s) / 4 + int'(s) % 4 + 1;
`else
    return int'(s) + 1;
`endif
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic run_op(input logic [1:0] o, input logic [31:0] l, input logic [4:0] s,
                        input logic [31:0] exp, input int hold);
    int cyc;
    logic [31:0] held;
    check("ready_before_req", {31'd0, ready}, 32'd1);
    req = 1'b1; op = o; lhs = l; shamt = s;
    exp_q.push_back(exp);
    lat_q.push_back(exp_lat(s));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      lhs = $urandom; shamt = 5'($urandom); op = 2'($urandom);
      if (!valid) begin
        check("gated_busy", result, 32'd0);
        req = 1'($urandom_range(0, 1));
      end else req = 1'b0;
    end while (!valid && cyc < 100);
    if (!valid) begin
      check("valid_timeout", {31'd0, valid}, 32'd1);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      return;
    end
    check("latency", cyc, lat_q.pop_front());
    check("result", result, exp_q.pop_front());
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, valid}, 32'd1);
      check("hold_result", result, held);
      check("hold_not_ready", {31'd0, ready}, 32'd0);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_valid_drop", {31'd0, valid}, 32'd0);
    check("ack_ready", {31'd0, ready}, 32'd1);
    check("ack_result_zero", result, 32'd0);
  endtask

  initial begin
    int bad;
    logic [1:0] o;
    logic [31:0] l;
    logic [4:0] s;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", result, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    bad = 0;
    req = 1'b1; op = 2'b00; lhs = 32'hFFFF_FFFF; shamt = 5'd3; ack = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (!ready || valid) bad++;
    end
    req = 1'b0; ack = 1'b0;
    check("nop_ignored", bad, 32'd0);
    run_op(2'b01, 32'h0000_0001, 5'd31, 32'h8000_0000, 0);
    run_op(2'b11, 32'h8000_0010, 5'd4,  32'hF800_0001, 1);
    run_op(2'b10, 32'h8000_0010, 5'd4,  32'h0800_0001, 0);
    run_op(2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 10);
    run_op(2'b01, 32'h0000_0003, 5'd2,  32'h0000_000C, 2);
    run_op(2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 0);
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(1, 3));
      l = $urandom;
      s = 5'($urandom);
      run_op(o, l, s, model(o, l, s), int'($urandom_range(0, 3)));
    end
    req = 1'b1; op = 2'b01; lhs = 32'h1; shamt = 5'd31;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check("shift_busy", {31'd0, ready}, 32'd0);
    resetn = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid || !ready || result != 32'd0) bad++;
    end
    check("no_spurious_valid", bad, 32'd0);
    run_op(2'b10, 32'h1234_5678, 5'd8, 32'h0012_3456, 0);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
